// File: rtl/vga_colour_filter_pkg.sv
// Shared definitions for the VGA colour-window filter.
// Holds the channel/counter widths, the configuration address map, the
// recolour mode encoding and the window register layout used by the
// interface, the comparator and the top level.
package vga_colour_filter_pkg;

    localparam int DW    = 8;     // colour channel width
    localparam int H_ACT = 640;   // active pixels per line
    localparam int V_ACT = 480;   // active lines per frame
    localparam int CNT_W = 19;    // match counter width (holds 640*480)
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    // Highlight colour {R,G,B} used by MODE_HIGHLIGHT.
    localparam logic [23:0] HL_COLOUR = 24'hFF00FF;

    // Configuration address map; 4..7 are unmapped.
    localparam logic [2:0] CFG_ADDR_R    = 3'd0;
    localparam logic [2:0] CFG_ADDR_G    = 3'd1;
    localparam logic [2:0] CFG_ADDR_B    = 3'd2;
    localparam logic [2:0] CFG_ADDR_MODE = 3'd3;

    typedef enum logic [1:0] {
        MODE_PASS      = 2'd0,  // pass-through
        MODE_MASK      = 2'd1,  // non-matching pixels forced black
        MODE_HIGHLIGHT = 2'd2,  // matching pixels replaced by HL_COLOUR
        MODE_BINARY    = 2'd3   // match -> white, else black
    } mode_e;

    // Window register as written by the CPU: {max[15:8], min[7:0]}.
    typedef struct packed {
        logic [DW-1:0] win_max;
        logic [DW-1:0] win_min;
    } win_t;

    localparam win_t WIN_RESET = '{win_max: 8'hFF, win_min: 8'h00};

endpackage

// File: rtl/vga_colour_filter_if.sv
// Pixel, configuration and statistics signals of the colour filter.
//   master : the VGA controller / CPU side (drives i*, observes o*)
//   slave  : the filter itself (observes i*, drives o*)
// Signals:
//   iR/iG/iB, iHS, iVS, iBLANK_N     incoming pixel stream (syncs active-low)
//   iCFG_WE, iCFG_ADDR, iCFG_WDATA   one-cycle configuration write
//   oR/oG/oB, oHS, oVS, oBLANK_N     filtered pixel stream (2-cycle latency)
//   oMATCH_CNT, oX/Y_MIN/MAX         statistics of the last complete frame
//   oBBOX_VALID, oSTAT_VALID         bbox validity, stats-update pulse
interface vga_colour_filter_if;
    import vga_colour_filter_pkg::*;

    logic [DW-1:0]    iR, iG, iB;
    logic             iHS, iVS, iBLANK_N;
    logic             iCFG_WE;
    logic [2:0]       iCFG_ADDR;
    logic [15:0]      iCFG_WDATA;

    logic [DW-1:0]    oR, oG, oB;
    logic             oHS, oVS, oBLANK_N;
    logic [CNT_W-1:0] oMATCH_CNT;
    logic [X_W-1:0]   oX_MIN, oX_MAX;
    logic [Y_W-1:0]   oY_MIN, oY_MAX;
    logic             oBBOX_VALID, oSTAT_VALID;

    modport master (
        output iR, iG, iB, iHS, iVS, iBLANK_N, iCFG_WE, iCFG_ADDR, iCFG_WDATA,
        input  oR, oG, oB, oHS, oVS, oBLANK_N, oMATCH_CNT,
               oX_MIN, oX_MAX, oY_MIN, oY_MAX, oBBOX_VALID, oSTAT_VALID
    );

    modport slave (
        input  iR, iG, iB, iHS, iVS, iBLANK_N, iCFG_WE, iCFG_ADDR, iCFG_WDATA,
        output oR, oG, oB, oHS, oVS, oBLANK_N, oMATCH_CNT,
               oX_MIN, oX_MAX, oY_MIN, oY_MAX, oBBOX_VALID, oSTAT_VALID
    );

endinterface

// File: rtl/vga_colour_filter_cmp.sv
// Single-channel inclusive window comparator.
//   c_i        channel value
//   min_i      window lower bound (inclusive)
//   max_i      window upper bound (inclusive)
//   in_range_o 1 when min_i <= c_i <= max_i; an inverted window never matches
module cf_window_cmp
    import vga_colour_filter_pkg::*;
(
    input  logic [DW-1:0] c_i,
    input  logic [DW-1:0] min_i,
    input  logic [DW-1:0] max_i,
    output logic          in_range_o
);

    assign in_range_o = (c_i >= min_i) && (c_i <= max_i);

endmodule

// File: rtl/vga_colour_filter.sv
// Colour-window filter between the VGA controller and the VGA pins.
// Each active pixel is classified against per-channel [min,max] windows and
// recoloured by mode; per-frame match count and bounding box are gathered.
// CPU config writes land in shadow registers and are copied into the active
// set at frame start (iVS falling edge) so a frame is never torn.
// Ports:
//   iCLK  pixel clock
//   iRST  asynchronous reset, active-high
//   vif   pixel/config/statistics bundle (slave side)
module vga_colour_filter
    import vga_colour_filter_pkg::*;
(
    input  logic               iCLK,
    input  logic               iRST,
    vga_colour_filter_if.slave vif
);

    logic                  vs_prev_q, blank_prev_q;
    logic                  frame_start, line_end;
    logic [2:0][DW-1:0]    pix_in;        // index 0 = R, 1 = G, 2 = B
    logic [2:0]            in_range;
    logic                  match_in;
    mode_e                 shadow_mode_q, active_mode_q;

    assign frame_start = vs_prev_q & ~vif.iVS;
    assign line_end    = blank_prev_q & ~vif.iBLANK_N;
    assign pix_in      = {vif.iB, vif.iG, vif.iR};
    assign match_in    = vif.iBLANK_N & (&in_range);

    // ---------------- per-channel windows and comparators ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            win_t shadow_q, active_q;

            always_ff @(posedge iCLK or posedge iRST) begin
                if (iRST) begin
                    shadow_q <= WIN_RESET;
                    active_q <= WIN_RESET;
                end else begin
                    if (vif.iCFG_WE && vif.iCFG_ADDR == 3'(gi))
                        shadow_q <= win_t'(vif.iCFG_WDATA);
                    // Non-blocking: a write on the frame-start cycle only
                    // reaches the active set one frame later.
                    if (frame_start)
                        active_q <= shadow_q;
                end
            end

            cf_window_cmp u_cmp (
                .c_i        (pix_in[gi]),
                .min_i      (active_q.win_min),
                .max_i      (active_q.win_max),
                .in_range_o (in_range[gi])
            );
        end
    endgenerate

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            shadow_mode_q <= MODE_PASS;
            active_mode_q <= MODE_PASS;
            vs_prev_q     <= 1'b1;
            blank_prev_q  <= 1'b0;
        end else begin
            if (vif.iCFG_WE && vif.iCFG_ADDR == CFG_ADDR_MODE)
                shadow_mode_q <= mode_e'(vif.iCFG_WDATA[1:0]);
            if (frame_start)
                active_mode_q <= shadow_mode_q;
            vs_prev_q    <= vif.iVS;
            blank_prev_q <= vif.iBLANK_N;
        end
    end

    // ---------------- position of the pixel currently at the input ----------------
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (frame_start) begin
            x_d = '0;
            y_d = '0;
        end else if (line_end) begin
            x_d = '0;
            if (y_q != Y_W'(V_ACT - 1))
                y_d = y_q + 1'b1;
        end else if (vif.iBLANK_N && x_q != X_W'(H_ACT - 1)) begin
            x_d = x_q + 1'b1;
        end
    end

    // ---------------- frame accumulators ----------------
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [X_W-1:0]   acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
    logic [Y_W-1:0]   acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
    logic             acc_valid_q, acc_valid_d;

    always_comb begin
        acc_cnt_d   = acc_cnt_q;
        acc_xmin_d  = acc_xmin_q;
        acc_xmax_d  = acc_xmax_q;
        acc_ymin_d  = acc_ymin_q;
        acc_ymax_d  = acc_ymax_q;
        acc_valid_d = acc_valid_q;
        if (frame_start) begin
            acc_cnt_d   = '0;
            acc_xmin_d  = '0;
            acc_xmax_d  = '0;
            acc_ymin_d  = '0;
            acc_ymax_d  = '0;
            acc_valid_d = 1'b0;
        end else if (match_in) begin
            if (acc_cnt_q != '1)
                acc_cnt_d = acc_cnt_q + 1'b1;
            acc_valid_d = 1'b1;
            if (!acc_valid_q) begin
                // First match of the frame seeds the whole box.
                acc_xmin_d = x_q;
                acc_xmax_d = x_q;
                acc_ymin_d = y_q;
                acc_ymax_d = y_q;
            end else begin
                if (x_q < acc_xmin_q) acc_xmin_d = x_q;
                if (x_q > acc_xmax_q) acc_xmax_d = x_q;
                if (y_q < acc_ymin_q) acc_ymin_d = y_q;
                if (y_q > acc_ymax_q) acc_ymax_d = y_q;
            end
        end
    end

    // ---------------- stage 1: classification result ----------------
    logic [2:0][DW-1:0] s1_pix_q;
    logic               s1_match_q, s1_hs_q, s1_vs_q, s1_blank_q;

    // ---------------- stage 2: recolour ----------------
    logic [2:0][DW-1:0] recol_d, out_pix_q;
    logic               out_hs_q, out_vs_q, out_blank_q;

    always_comb begin
        recol_d = s1_pix_q;
        case (active_mode_q)
            MODE_PASS:      recol_d = s1_pix_q;
            MODE_MASK:      if (!s1_match_q) recol_d = '0;
            MODE_HIGHLIGHT: if (s1_match_q)
                                recol_d = {HL_COLOUR[7:0], HL_COLOUR[15:8], HL_COLOUR[23:16]};
            MODE_BINARY:    recol_d = s1_match_q ? '1 : '0;
            default:        recol_d = s1_pix_q;
        endcase
        if (!s1_blank_q)
            recol_d = '0;
    end

    // ---------------- statistics outputs ----------------
    logic [CNT_W-1:0] stat_cnt_q;
    logic [X_W-1:0]   stat_xmin_q, stat_xmax_q;
    logic [Y_W-1:0]   stat_ymin_q, stat_ymax_q;
    logic             stat_bbox_valid_q, stat_pulse_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            x_q               <= '0;
            y_q               <= '0;
            acc_cnt_q         <= '0;
            acc_xmin_q        <= '0;
            acc_xmax_q        <= '0;
            acc_ymin_q        <= '0;
            acc_ymax_q        <= '0;
            acc_valid_q       <= 1'b0;
            s1_pix_q          <= '0;
            s1_match_q        <= 1'b0;
            s1_hs_q           <= 1'b1;
            s1_vs_q           <= 1'b1;
            s1_blank_q        <= 1'b0;
            out_pix_q         <= '0;
            out_hs_q          <= 1'b1;
            out_vs_q          <= 1'b1;
            out_blank_q       <= 1'b0;
            stat_cnt_q        <= '0;
            stat_xmin_q       <= '0;
            stat_xmax_q       <= '0;
            stat_ymin_q       <= '0;
            stat_ymax_q       <= '0;
            stat_bbox_valid_q <= 1'b0;
            stat_pulse_q      <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_xmin_q  <= acc_xmin_d;
            acc_xmax_q  <= acc_xmax_d;
            acc_ymin_q  <= acc_ymin_d;
            acc_ymax_q  <= acc_ymax_d;
            acc_valid_q <= acc_valid_d;
            s1_pix_q    <= pix_in;
            s1_match_q  <= match_in;
            s1_hs_q     <= vif.iHS;
            s1_vs_q     <= vif.iVS;
            s1_blank_q  <= vif.iBLANK_N;
            out_pix_q   <= recol_d;
            out_hs_q    <= s1_hs_q;
            out_vs_q    <= s1_vs_q;
            out_blank_q <= s1_blank_q;
            stat_pulse_q <= frame_start;
            if (frame_start) begin
                stat_cnt_q        <= acc_cnt_q;
                stat_bbox_valid_q <= acc_valid_q;
                stat_xmin_q       <= acc_valid_q ? acc_xmin_q : '0;
                stat_xmax_q       <= acc_valid_q ? acc_xmax_q : '0;
                stat_ymin_q       <= acc_valid_q ? acc_ymin_q : '0;
                stat_ymax_q       <= acc_valid_q ? acc_ymax_q : '0;
            end
        end
    end

    assign vif.oR          = out_pix_q[0];
    assign vif.oG          = out_pix_q[1];
    assign vif.oB          = out_pix_q[2];
    assign vif.oHS         = out_hs_q;
    assign vif.oVS         = out_vs_q;
    assign vif.oBLANK_N    = out_blank_q;
    assign vif.oMATCH_CNT  = stat_cnt_q;
    assign vif.oX_MIN      = stat_xmin_q;
    assign vif.oX_MAX      = stat_xmax_q;
    assign vif.oY_MIN      = stat_ymin_q;
    assign vif.oY_MAX      = stat_ymax_q;
    assign vif.oBBOX_VALID = stat_bbox_valid_q;
    assign vif.oSTAT_VALID = stat_pulse_q;

endmodule

// File: tb/tb_vga_colour_filter.sv
// Directed self-checking bench for vga_colour_filter.
module tb_vga_colour_filter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vga_colour_filter_if vif ();

    vga_colour_filter dut (
        .iCLK (clk),
        .iRST (rst),
        .vif  (vif)
    );

    // Drive one pixel for one clock; returns 1ns after the sampling edge.
    // The output stream then shows the pixel driven by the previous call.
    task automatic px(input logic [7:0] r, g, b, input logic hs, vs, bl);
        vif.iR = r; vif.iG = g; vif.iB = b;
        vif.iHS = hs; vif.iVS = vs; vif.iBLANK_N = bl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        px(8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
        vif.iCFG_WE = 1'b1; vif.iCFG_ADDR = a; vif.iCFG_WDATA = d;
        idle();
        vif.iCFG_WE = 1'b0;
    endtask

    // VS low for two cycles then idle; optional config write on the VS-fall
    // cycle only. Reports how many oSTAT_VALID pulses were seen.
    task automatic vs_frame(input logic we, input logic [2:0] a, input logic [15:0] d,
                            output int pulses);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            vif.iCFG_WE = we && (i == 0); vif.iCFG_ADDR = a; vif.iCFG_WDATA = d;
            px(8'd0, 8'd0, 8'd0, 1'b1, (i < 2) ? 1'b0 : 1'b1, 1'b0);
            if (vif.oSTAT_VALID) pulses++;
        end
        vif.iCFG_WE = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] got;
        idle();
        idle();
        got = {vif.oR, vif.oG, vif.oB, vif.oHS, vif.oVS, vif.oBLANK_N};
        checks++;
        if (got !== {24'h0, 1'b1, 1'b1, 1'b0}) begin
            failures++; $display("FAIL reset_pixel_out: got %h expected %h", got, {24'h0, 3'b110});
        end else $display("reset pixel outputs %h", got);
        checks++;
        if ({vif.oMATCH_CNT, vif.oX_MIN, vif.oX_MAX, vif.oY_MIN, vif.oY_MAX,
             vif.oBBOX_VALID, vif.oSTAT_VALID} !== 59'd0) begin
            failures++; $display("FAIL reset_stats: got cnt=%0d bbox_valid=%b stat_valid=%b expected all 0",
                                 vif.oMATCH_CNT, vif.oBBOX_VALID, vif.oSTAT_VALID);
        end else $display("reset stats zero");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if (vif.oSTAT_VALID !== 1'b0) begin
                failures++; $display("FAIL reset_release_pulse: got %b expected 0", vif.oSTAT_VALID);
            end else $display("post-reset cycle %0d no stat pulse", i);
        end
    endtask

    // Mode 0 with reset windows: output = input two cycles later, blanked -> 0.
    task automatic test_passthrough();
        logic [7:0] r [20], g [20], b [20];
        logic       hs [20], vs [20], bl [20];
        logic [26:0] got, exp;
        for (int i = 0; i < 20; i++) begin
            r[i]  = 8'(i * 10 + 5);
            g[i]  = 8'(8'hF0 - i);
            b[i]  = 8'(i) ^ 8'h55;
            bl[i] = (i >= 3 && i < 15);
            hs[i] = !(i >= 15 && i < 18);
            vs[i] = (i != 18);
        end
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) px(r[i], g[i], b[i], hs[i], vs[i], bl[i]);
            else        idle();
            if (i >= 1) begin
                exp = {bl[i-1] ? {r[i-1], g[i-1], b[i-1]} : 24'h0, hs[i-1], vs[i-1], bl[i-1]};
                got = {vif.oR, vif.oG, vif.oB, vif.oHS, vif.oVS, vif.oBLANK_N};
                checks++;
                if (got !== exp) begin
                    failures++; $display("FAIL passthrough[%0d]: got %h expected %h", i - 1, got, exp);
                end else $display("passthrough pixel %0d out %h", i - 1, got);
            end
        end
    endtask

    // R window [100,200], mode 3: inclusive bounds.
    task automatic test_window_binary();
        logic [7:0]  rv [4] = '{8'd100, 8'd200, 8'd99, 8'd201};
        logic [23:0] ev [4] = '{24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};
        int p;
        cfg_write(3'd0, 16'hC864);
        cfg_write(3'd3, 16'h0003);
        vs_frame(1'b0, 3'd0, 16'h0, p);
        for (int i = 0; i < 4; i++) begin
            px(rv[i], 8'd128, 8'd128, 1'b1, 1'b1, 1'b1);
            idle();
            checks++;
            if ({vif.oR, vif.oG, vif.oB} !== ev[i]) begin
                failures++; $display("FAIL binary_R%0d: got %h expected %h", rv[i], {vif.oR, vif.oG, vif.oB}, ev[i]);
            end else $display("binary R=%0d out %h", rv[i], {vif.oR, vif.oG, vif.oB});
        end
    endtask

    // Mid-frame write is deferred; a write on the VS-fall cycle is two frames out.
    task automatic test_window_update();
        logic [23:0] ev [5] = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        logic [7:0]  rv [5] = '{8'd50, 8'd50, 8'd50, 8'd50, 8'd150};
        int p;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: cfg_write(3'd0, 16'hFF00);                    // mid-frame
                1: vs_frame(1'b0, 3'd0, 16'h0, p);
                2: vs_frame(1'b1, 3'd0, 16'hC864, p);            // write on VS fall
                3: vs_frame(1'b0, 3'd0, 16'h0, p);
                default: begin                                   // unmapped writes
                    cfg_write(3'd4, 16'h0000);
                    cfg_write(3'd7, 16'h0000);
                    vs_frame(1'b0, 3'd0, 16'h0, p);
                end
            endcase
            px(rv[i], 8'd128, 8'd128, 1'b1, 1'b1, 1'b1);
            idle();
            checks++;
            if ({vif.oR, vif.oG, vif.oB} !== ev[i]) begin
                failures++; $display("FAIL update_step%0d: got %h expected %h", i, {vif.oR, vif.oG, vif.oB}, ev[i]);
            end else $display("update step %0d out %h", i, {vif.oR, vif.oG, vif.oB});
        end
    endtask

    // 10x4 match block at x=300..309, y=50..53.
    task automatic test_frame_stats();
        logic [57:0] got, exp;
        int p;
        vs_frame(1'b0, 3'd0, 16'h0, p);
        for (int y = 0; y < 54; y++) begin
            idle();
            idle();
            for (int x = 0; x < 310; x++)
                px((y >= 50 && x >= 300) ? 8'd150 : 8'd50, 8'd128, 8'd128, 1'b1, 1'b1, 1'b1);
        end
        idle();
        vs_frame(1'b0, 3'd0, 16'h0, p);
        checks++;
        if (p !== 1) begin
            failures++; $display("FAIL block_pulses: got %0d expected 1", p);
        end else $display("block frame stat pulses %0d", p);
        got = {vif.oMATCH_CNT, vif.oX_MIN, vif.oX_MAX, vif.oY_MIN, vif.oY_MAX, vif.oBBOX_VALID};
        exp = {19'd40, 10'd300, 10'd309, 9'd50, 9'd53, 1'b1};
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL block_stats: got cnt=%0d x=%0d..%0d y=%0d..%0d v=%b expected %h",
                                 vif.oMATCH_CNT, vif.oX_MIN, vif.oX_MAX, vif.oY_MIN, vif.oY_MAX, vif.oBBOX_VALID, exp);
        end else $display("block stats cnt=%0d x=%0d..%0d y=%0d..%0d", vif.oMATCH_CNT,
                          vif.oX_MIN, vif.oX_MAX, vif.oY_MIN, vif.oY_MAX);
    endtask

    // Inverted G window: nothing matches, bbox forced to 0, mode 1 all black.
    task automatic test_invalid_window();
        logic [7:0] rv [5] = '{8'd150, 8'd0,   8'd255, 8'd128, 8'd128};
        logic [7:0] gv [5] = '{8'd15,  8'd0,   8'd255, 8'd20,  8'd10};
        logic [57:0] got, exp;
        int p;
        for (int i = 0; i < 5; i++)
            px((i == 4) ? 8'd150 : 8'd50, 8'd128, 8'd128, 1'b1, 1'b1, 1'b1);
        idle();
        cfg_write(3'd1, 16'h0A14);
        cfg_write(3'd3, 16'h0001);
        cfg_write(3'd0, 16'hFF00);
        vs_frame(1'b0, 3'd0, 16'h0, p);
        got = {vif.oMATCH_CNT, vif.oX_MIN, vif.oX_MAX, vif.oY_MIN, vif.oY_MAX, vif.oBBOX_VALID};
        exp = {19'd1, 10'd4, 10'd4, 9'd0, 9'd0, 1'b1};
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL single_match_stats: got %h expected %h", got, exp);
        end else $display("single match stats x=%0d cnt=%0d", vif.oX_MIN, vif.oMATCH_CNT);
        for (int i = 0; i < 5; i++) begin
            px(rv[i], gv[i], 8'd128, 1'b1, 1'b1, 1'b1);
            idle();
            checks++;
            if ({vif.oR, vif.oG, vif.oB} !== 24'h0) begin
                failures++; $display("FAIL mask_black%0d: got %h expected 000000", i, {vif.oR, vif.oG, vif.oB});
            end else $display("mask pixel %0d out %h", i, {vif.oR, vif.oG, vif.oB});
        end
        vs_frame(1'b0, 3'd0, 16'h0, p);
        got = {vif.oMATCH_CNT, vif.oX_MIN, vif.oX_MAX, vif.oY_MIN, vif.oY_MAX, vif.oBBOX_VALID};
        checks++;
        if (got !== 58'd0) begin
            failures++; $display("FAIL invalid_stats: got %h expected 0", got);
        end else $display("invalid window stats zero, pulses %0d", p);
    endtask

    // x saturates at 639, y at 479.
    task automatic test_saturation();
        logic [57:0] got, exp;
        int p;
        cfg_write(3'd0, 16'hC864);
        cfg_write(3'd1, 16'hFF00);
        cfg_write(3'd3, 16'h0000);
        vs_frame(1'b0, 3'd0, 16'h0, p);
        for (int i = 0; i < 645; i++)
            px((i >= 643) ? 8'd150 : 8'd50, 8'd128, 8'd128, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 500; k++) begin
            idle();
            px((k == 500) ? 8'd150 : 8'd50, 8'd128, 8'd128, 1'b1, 1'b1, 1'b1);
        end
        idle();
        vs_frame(1'b0, 3'd0, 16'h0, p);
        got = {vif.oMATCH_CNT, vif.oX_MIN, vif.oX_MAX, vif.oY_MIN, vif.oY_MAX, vif.oBBOX_VALID};
        exp = {19'd3, 10'd0, 10'd639, 9'd0, 9'd479, 1'b1};
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL saturation_stats: got cnt=%0d x=%0d..%0d y=%0d..%0d expected cnt=3 x=0..639 y=0..479",
                                 vif.oMATCH_CNT, vif.oX_MIN, vif.oX_MAX, vif.oY_MIN, vif.oY_MAX);
        end else $display("saturation stats x=%0d..%0d y=%0d..%0d", vif.oX_MIN, vif.oX_MAX, vif.oY_MIN, vif.oY_MAX);
    endtask

    task automatic test_reset_midframe();
        logic [57:0] got, exp;
        int p;
        px(8'd10, 8'd20, 8'd30, 1'b1, 1'b1, 1'b1);
        px(8'd40, 8'd50, 8'd60, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({vif.oR, vif.oG, vif.oB, vif.oBLANK_N} !== {24'h0A141E, 1'b1}) begin
            failures++; $display("FAIL prereset_out: got %h expected 0a141e1", {vif.oR, vif.oG, vif.oB, vif.oBLANK_N});
        end else $display("pre-reset out %h", {vif.oR, vif.oG, vif.oB});
        rst = 1'b1;
        #1;
        checks++;
        if ({vif.oR, vif.oG, vif.oB, vif.oHS, vif.oVS, vif.oBLANK_N} !== {24'h0, 3'b110}) begin
            failures++; $display("FAIL midreset_pixel: got %h expected %h",
                                 {vif.oR, vif.oG, vif.oB, vif.oHS, vif.oVS, vif.oBLANK_N}, {24'h0, 3'b110});
        end else $display("mid-frame reset pixel outputs cleared");
        checks++;
        if ({vif.oMATCH_CNT, vif.oX_MAX, vif.oY_MAX, vif.oBBOX_VALID, vif.oSTAT_VALID} !== 50'd0) begin
            failures++; $display("FAIL midreset_stats: got cnt=%0d xmax=%0d v=%b expected 0",
                                 vif.oMATCH_CNT, vif.oX_MAX, vif.oBBOX_VALID);
        end else $display("mid-frame reset stats cleared");
        idle();
        idle();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i >= 2 && i < 7) px(8'd10, 8'd20, 8'd30, 1'b1, 1'b1, 1'b1);
            else                 idle();
            checks++;
            if (vif.oSTAT_VALID !== 1'b0) begin
                failures++; $display("FAIL postreset_pulse%0d: got 1 expected 0", i);
            end else $display("post-reset cycle %0d no stat pulse", i);
        end
        vs_frame(1'b0, 3'd0, 16'h0, p);
        checks++;
        if (p !== 1) begin
            failures++; $display("FAIL postreset_pulses: got %0d expected 1", p);
        end else $display("post-reset frame pulses %0d", p);
        got = {vif.oMATCH_CNT, vif.oX_MIN, vif.oX_MAX, vif.oY_MIN, vif.oY_MAX, vif.oBBOX_VALID};
        exp = {19'd5, 10'd0, 10'd4, 9'd0, 9'd0, 1'b1};
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL postreset_stats: got %h expected %h", got, exp);
        end else $display("post-reset stats cnt=%0d x=%0d..%0d", vif.oMATCH_CNT, vif.oX_MIN, vif.oX_MAX);
    endtask

    initial begin
        vif.iR = '0; vif.iG = '0; vif.iB = '0;
        vif.iHS = 1'b1; vif.iVS = 1'b1; vif.iBLANK_N = 1'b0;
        vif.iCFG_WE = 1'b0; vif.iCFG_ADDR = '0; vif.iCFG_WDATA = '0;
        test_reset();
        test_passthrough();
        test_window_binary();
        test_window_update();
        test_frame_stats();
        test_invalid_window();
        test_saturation();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
